// File: rtl/decoder_proj_pkg.sv
// decoder_proj_pkg: Hamming(7,4) layout shared by the encoder and decoder ends of the link
package decoder_proj_pkg;
  localparam int CW_W = 7;
  localparam int DATA_W = 4;
  localparam int INJ_W = 3;
  localparam int P1_POS = 0;
  localparam int P2_POS = 1;
  localparam int P3_POS = 3;
  function automatic logic [CW_W-1:0] hamming74_enc(input logic [DATA_W-1:0] d);
    logic [CW_W-1:0] c;
    c = '0;
    c[2] = d[0];
    c[4] = d[1];
    c[5] = d[2];
    c[6] = d[3];
    c[P1_POS] = d[0] ^ d[1] ^ d[3];
    c[P2_POS] = d[0] ^ d[2] ^ d[3];
    c[P3_POS] = d[1] ^ d[2] ^ d[3];
    return c;
  endfunction
  // position 0 means a clean word; 1..7 selects the Hamming position to flip
  function automatic logic [CW_W-1:0] inj_mask(input logic [INJ_W-1:0] pos);
    return (pos == '0) ? '0 : CW_W'(1) << (pos - 3'd1);
  endfunction
endpackage

// File: rtl/decoder_proj_encoder_if.sv
// decoder_proj_encoder_if: nibble input stream and codeword output stream of the encoder
interface decoder_proj_encoder_if;
  import decoder_proj_pkg::*;
  logic in_valid;
  logic in_ready;
  logic [DATA_W-1:0] in_data;
  logic [INJ_W-1:0] in_inj_pos;
  logic cw_valid;
  logic cw_ready;
  logic [CW_W-1:0] cw_data;
  modport master(output in_valid, in_data, in_inj_pos, cw_ready, input in_ready, cw_valid, cw_data);
  modport slave(input in_valid, in_data, in_inj_pos, cw_ready, output in_ready, cw_valid, cw_data);
endinterface

// File: rtl/decoder_proj_fifo.sv
// decoder_proj_fifo: WIDTH x DEPTH synchronous FIFO with extra-MSB pointers for full/empty
module decoder_proj_fifo #(
  parameter int WIDTH = 7,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic wr;
  always_comb begin
    full = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    empty = wr_ptr_q == rd_ptr_q;
    wr = push && !full;
    mem_d = mem_q;
    if (wr) mem_d[wr_ptr_q[AW-1:0]] = wdata;
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, wr};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop && !empty};
    rdata = mem_q[rd_ptr_q[AW-1:0]];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      mem_q <= '{default: '0};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q <= mem_d;
    end
  end
endmodule

// File: rtl/decoder_proj_encoder.sv
// decoder_proj_encoder: buffers nibbles, Hamming(7,4)-encodes with optional bit injection, registered output
module decoder_proj_encoder
  import decoder_proj_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic wb_clk_i,
  input  logic wb_rst_i,
  decoder_proj_encoder_if.slave bus,
  input  logic ctr_clr,
  output logic [CNT_W-1:0] cw_count,
  output logic [7:0] inj_count
);
  localparam int ENT_W = INJ_W + DATA_W;
  logic [ENT_W-1:0] head;
  logic full, empty, load, beat;
  logic cw_valid_q, cw_valid_d, inj_q, inj_d;
  logic [CW_W-1:0] cw_data_q, cw_data_d;
  logic [CNT_W-1:0] cw_count_q, cw_count_d;
  logic [7:0] inj_count_q, inj_count_d;
  decoder_proj_fifo #(.WIDTH(ENT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(wb_clk_i),
    .rst(wb_rst_i),
    .push(bus.in_valid),
    .pop(load),
    .wdata({bus.in_inj_pos, bus.in_data}),
    .rdata(head),
    .full(full),
    .empty(empty)
  );
  // inj_q tracks whether the word in the output register was corrupted, for inj_count
  always_comb begin
    load = !empty && (!cw_valid_q || bus.cw_ready);
    beat = cw_valid_q && bus.cw_ready;
    cw_valid_d = load || (cw_valid_q && !bus.cw_ready);
    cw_data_d = load ? hamming74_enc(head[DATA_W-1:0]) ^ inj_mask(head[ENT_W-1:DATA_W]) : cw_data_q;
    inj_d = load ? (head[ENT_W-1:DATA_W] != '0) : inj_q;
    cw_count_d = ctr_clr ? '0 : cw_count_q + CNT_W'(beat);
    inj_count_d = ctr_clr ? '0 : inj_count_q + 8'(beat && inj_q && inj_count_q != 8'hFF);
  end
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      cw_valid_q <= 1'b0;
      cw_data_q <= '0;
      inj_q <= 1'b0;
      cw_count_q <= '0;
      inj_count_q <= '0;
    end else begin
      cw_valid_q <= cw_valid_d;
      cw_data_q <= cw_data_d;
      inj_q <= inj_d;
      cw_count_q <= cw_count_d;
      inj_count_q <= inj_count_d;
    end
  end
  assign bus.in_ready = !full;
  assign bus.cw_valid = cw_valid_q;
  assign bus.cw_data = cw_data_q;
  assign cw_count = cw_count_q;
  assign inj_count = inj_count_q;
endmodule

// File: tb/tb_decoder_proj_encoder.sv
// tb_decoder_proj_encoder: vector table, corner sequences, and scoreboarded random/loopback streams
module tb_decoder_proj_encoder;
  import decoder_proj_pkg::*;
  typedef struct {
    logic [3:0] d;
    logic [2:0] inj;
    logic [6:0] cw;
  } vec_t;
  typedef struct {
    logic [3:0] d;
    logic [2:0] inj;
  } item_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ctr_clr = 1'b0;
  logic [15:0] cw_count;
  logic [7:0] inj_count;
  int total = 0;
  int bad = 0;
  decoder_proj_encoder_if bus();
  decoder_proj_encoder #(.FIFO_DEPTH(4), .CNT_W(16)) dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .bus(bus),
    .ctr_clr(ctr_clr),
    .cw_count(cw_count),
    .inj_count(inj_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  // generic Hamming: data in non-power-of-two positions, parity p covers positions with bit p set
  function automatic logic [6:0] ref_cw(input logic [3:0] d, input logic [2:0] inj);
    logic [6:0] c;
    int dp[4];
    dp = '{3, 5, 6, 7};
    c = '0;
    for (int i = 0; i < 4; i++) c[dp[i]-1] = d[i];
    for (int p = 1; p < 8; p = p * 2)
      for (int k = 1; k < 8; k++)
        if ((k & p) != 0 && k != p) c[p-1] = c[p-1] ^ c[k-1];
    if (inj != 0) c[inj-1] = ~c[inj-1];
    return c;
  endfunction
  function automatic logic [3:0] ref_dec(input logic [6:0] cw);
    int s;
    s = 0;
    for (int k = 1; k < 8; k++) if (cw[k-1]) s = s ^ k;
    if (s != 0) cw[s-1] = ~cw[s-1];
    return {cw[6], cw[5], cw[4], cw[2]};
  endfunction
  task automatic do_reset;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.cw_ready = 1'b0;
    ctr_clr = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask
  task automatic push(input logic [3:0] d, input logic [2:0] inj);
    int n;
    bus.in_valid = 1'b1;
    bus.in_data = d;
    bus.in_inj_pos = inj;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      tick();
      n++;
    end
    if (n == 20) chk("push_timeout", 0, 1);
    tick();
    bus.in_valid = 1'b0;
  endtask
  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!bus.cw_valid && n < 20) begin
      tick();
      n++;
    end
    if (n == 20) chk(name, 0, 1);
  endtask
  task automatic run_stream(input bit rnd, input int n);
    item_t items[$];
    item_t exp_q[$];
    item_t it, e;
    int idx, cyc, inj_m;
    logic [15:0] cnt_m;
    logic prev_stall;
    logic [6:0] prev_data;
    for (int i = 0; i < n; i++) begin
      it.d = rnd ? 4'($urandom) : 4'(i % 16);
      it.inj = rnd ? 3'($urandom) : 3'(i / 16);
      items.push_back(it);
    end
    idx = 0;
    cnt_m = 0;
    inj_m = 0;
    prev_stall = 1'b0;
    prev_data = '0;
    for (cyc = 0; cyc < 5000; cyc++) begin
      if (idx == n && exp_q.size() == 0 && !bus.cw_valid) break;
      bus.in_valid = idx < n && (!rnd || ($urandom % 4) != 0);
      if (idx < n) begin
        bus.in_data = items[idx].d;
        bus.in_inj_pos = items[idx].inj;
      end
      bus.cw_ready = !rnd || ($urandom % 3) != 0;
      ctr_clr = rnd && ($urandom % 32) == 0;
      if (prev_stall) begin
        chk("stall_valid", 32'(bus.cw_valid), 1);
        chk("stall_data", 32'(bus.cw_data), 32'(prev_data));
      end
      if (bus.cw_valid && bus.cw_ready) begin
        if (exp_q.size() == 0) chk("unexpected_word", 32'(bus.cw_data), 0);
        else begin
          e = exp_q.pop_front();
          chk("stream_cw", 32'(bus.cw_data), 32'(ref_cw(e.d, e.inj)));
          chk("loopback", 32'(ref_dec(bus.cw_data)), 32'(e.d));
          if (!ctr_clr) begin
            cnt_m++;
            if (e.inj != 0 && inj_m < 255) inj_m++;
          end
        end
      end
      if (ctr_clr) begin
        cnt_m = 0;
        inj_m = 0;
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(items[idx]);
        idx++;
      end
      prev_stall = bus.cw_valid && !bus.cw_ready;
      prev_data = bus.cw_data;
      tick();
      chk("cw_count", 32'(cw_count), 32'(cnt_m));
      chk("inj_count", 32'(inj_count), 32'(inj_m));
    end
    if (cyc == 5000) chk("stream_timeout", 0, 1);
    bus.in_valid = 1'b0;
    ctr_clr = 1'b0;
  endtask
  initial begin
    vec_t vt[7];
    vt[0] = '{4'b1011, 3'd0, 7'b1010101};
    vt[1] = '{4'h0, 3'd0, 7'b0000000};
    vt[2] = '{4'hF, 3'd0, 7'b1111111};
    vt[3] = '{4'b0001, 3'd0, 7'b0000111};
    vt[4] = '{4'b0001, 3'd3, 7'b0000011};
    vt[5] = '{4'b0101, 3'd7, 7'b1101101};
    vt[6] = '{4'b1000, 3'd1, 7'b1001010};
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_inj_pos = '0;
    bus.cw_ready = 1'b0;
    do_reset();
    chk("rst_cw_valid", 32'(bus.cw_valid), 0);
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    chk("rst_cw_data", 32'(bus.cw_data), 0);
    chk("rst_cw_count", 32'(cw_count), 0);
    chk("rst_inj_count", 32'(inj_count), 0);
    bus.cw_ready = 1'b1;
    foreach (vt[i]) begin
      push(vt[i].d, vt[i].inj);
      wait_valid("vec_timeout");
      chk($sformatf("vec%0d", i), 32'(bus.cw_data), 32'(vt[i].cw));
      tick();
    end
    chk("vec_cw_count", 32'(cw_count), 7);
    chk("vec_inj_count", 32'(inj_count), 3);
    do_reset();
    bus.cw_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data = 4'b1011;
    bus.in_inj_pos = 3'd0;
    tick();
    bus.in_valid = 1'b0;
    chk("lat_edge_n", 32'(bus.cw_valid), 0);
    tick();
    chk("lat_edge_n1", 32'(bus.cw_valid), 1);
    chk("lat_data", 32'(bus.cw_data), 32'(7'b1010101));
    tick();
    chk("lat_count", 32'(cw_count), 1);
    chk("lat_drained", 32'(bus.cw_valid), 0);
    bus.in_valid = 1'b1;
    bus.in_data = 4'h0;
    tick();
    bus.in_data = 4'hF;
    tick();
    bus.in_valid = 1'b0;
    chk("b2b_first", 32'(bus.cw_data), 0);
    tick();
    chk("b2b_second", 32'(bus.cw_data), 32'(7'h7F));
    chk("b2b_valid", 32'(bus.cw_valid), 1);
    tick();
    do_reset();
    bus.cw_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_inj_pos = 3'd0;
    for (int i = 0; i < 5; i++) begin
      bus.in_data = 4'(i + 1);
      chk($sformatf("bp_ready%0d", i), 32'(bus.in_ready), 1);
      tick();
    end
    bus.in_data = 4'd6;
    chk("bp_full", 32'(bus.in_ready), 0);
    tick();
    tick();
    chk("bp_still_full", 32'(bus.in_ready), 0);
    chk("bp_stable", 32'(bus.cw_data), 32'(ref_cw(4'd1, 3'd0)));
    bus.in_valid = 1'b0;
    bus.cw_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_drain_v%0d", i), 32'(bus.cw_valid), 1);
      chk($sformatf("bp_drain_d%0d", i), 32'(bus.cw_data), 32'(ref_cw(4'(i + 1), 3'd0)));
      tick();
    end
    chk("bp_empty", 32'(bus.cw_valid), 0);
    bus.cw_ready = 1'b0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_data = 4'(9 + i);
      tick();
    end
    bus.in_valid = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    chk("arst_cw_valid", 32'(bus.cw_valid), 0);
    chk("arst_in_ready", 32'(bus.in_ready), 1);
    chk("arst_cw_data", 32'(bus.cw_data), 0);
    tick();
    rst = 1'b0;
    bus.cw_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("arst_no_old", 32'(bus.cw_valid), 0);
      tick();
    end
    push(4'h3, 3'd2);
    wait_valid("clr_timeout");
    tick();
    push(4'h4, 3'd5);
    wait_valid("clr_timeout2");
    chk("clr_pre_count", 32'(cw_count), 1);
    ctr_clr = 1'b1;
    tick();
    ctr_clr = 1'b0;
    chk("clr_cw_count", 32'(cw_count), 0);
    chk("clr_inj_count", 32'(inj_count), 0);
    chk("clr_consumed", 32'(bus.cw_valid), 0);
    do_reset();
    run_stream(1'b0, 128);
    do_reset();
    run_stream(1'b1, 300);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
